// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves conditional branches from the ALU zero-compare word, latches the
//   branch target, optionally waits for the delay-slot instruction to issue,
//   then presents a redirect to fetch over a valid/ready handshake. Keeps
//   saturating counters of accepted and taken branches.
//
// Parameters
//   DS_EN  1: redirect only after the delay-slot instruction issues; 0: no wait
//   CNT_W  width of the branch / taken statistics counters
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   br_valid/br_ready branch handshake (ready only while idle)
//   cmp_s, br_invert  condition word (true iff non-zero) and inversion select
//   pc_plus4, imm16   branch PC + 4 and signed word offset
//   ds_issue          delay-slot instruction accepted downstream
//   flush             aborts any pending branch; blocks acceptance this cycle
//   redirect_*        target PC handshake towards fetch
//   busy              a taken branch is being held
//   br_count          accepted branches (saturating)
//   taken_count       accepted taken branches (saturating)
module branch_resolve_unit #(
    parameter int unsigned DS_EN = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [31:0]      cmp_s,
    input  logic             br_invert,
    input  logic [31:0]      pc_plus4,
    input  logic [15:0]      imm16,
    input  logic             ds_issue,
    input  logic             flush,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DS,
        REDIRECT
    } state_t;

    state_t             state_q, state_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]   br_count_q, br_count_d;
    logic [CNT_W-1:0]   taken_count_q, taken_count_d;

    logic               accept;
    logic               taken;
    logic [31:0]        target;

    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        br_count_d       = br_count_q;
        taken_count_d    = taken_count_q;

        // A branch presented during a flush is dropped, not accepted.
        accept = br_valid & (state_q == IDLE) & ~flush;
        taken  = (|cmp_s) ^ br_invert;
        target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

        case (state_q)
            IDLE: begin
                if (accept && taken) begin
                    state_d = (DS_EN != 0) ? WAIT_DS : REDIRECT;
                end
            end
            WAIT_DS: begin
                if (ds_issue) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_valid_q && redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end

        // Registered valid tracks the next state so it rises in the first
        // cycle spent in REDIRECT and falls right after the handshake.
        redirect_valid_d = (state_d == REDIRECT);

        if (accept) begin
            redirect_pc_d = target;
            if (br_count_q != '1) begin
                br_count_d = br_count_q + 1'b1;
            end
            if (taken && (taken_count_q != '1)) begin
                taken_count_d = taken_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            taken_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign br_ready       = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit. Two instances share all inputs:
//   u0: DS_EN=1, CNT_W=16    u1: DS_EN=0, CNT_W=2
// A transaction-level reference model predicts every output each cycle.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset, br_valid, br_invert, ds_issue, flush, redirect_ready;
    logic [31:0] cmp_s, pc_plus4;
    logic [15:0] imm16;

    logic        br_ready0, redirect_valid0, busy0;
    logic [31:0] redirect_pc0;
    logic [15:0] br_count0, taken_count0;
    logic        br_ready1, redirect_valid1, busy1;
    logic [31:0] redirect_pc1;
    logic [1:0]  br_count1, taken_count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DS_EN(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready0),
        .cmp_s(cmp_s), .br_invert(br_invert), .pc_plus4(pc_plus4), .imm16(imm16),
        .ds_issue(ds_issue), .flush(flush), .redirect_valid(redirect_valid0),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc0), .busy(busy0),
        .br_count(br_count0), .taken_count(taken_count0)
    );

    branch_resolve_unit #(.DS_EN(0), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready1),
        .cmp_s(cmp_s), .br_invert(br_invert), .pc_plus4(pc_plus4), .imm16(imm16),
        .ds_issue(ds_issue), .flush(flush), .redirect_valid(redirect_valid1),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc1), .busy(busy1),
        .br_count(br_count1), .taken_count(taken_count1)
    );

    // Reference model: per instance, whether a taken branch is held, whether
    // it still awaits its delay slot, the latched target and the tallies.
    bit          m_hold [2];
    bit          m_need_ds [2];
    logic [31:0] m_pc [2];
    int unsigned m_bc [2];
    int unsigned m_tc [2];
    int unsigned m_max [2] = '{65535, 3};
    bit          m_ds_en [2] = '{1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("u0.br_ready", 32'(br_ready0), 32'(!m_hold[0]));
        chk("u0.busy", 32'(busy0), 32'(m_hold[0]));
        chk("u0.redirect_valid", 32'(redirect_valid0), 32'(m_hold[0] && !m_need_ds[0]));
        chk("u0.redirect_pc", redirect_pc0, m_pc[0]);
        chk("u0.br_count", 32'(br_count0), m_bc[0]);
        chk("u0.taken_count", 32'(taken_count0), m_tc[0]);
        chk("u1.br_ready", 32'(br_ready1), 32'(!m_hold[1]));
        chk("u1.busy", 32'(busy1), 32'(m_hold[1]));
        chk("u1.redirect_valid", 32'(redirect_valid1), 32'(m_hold[1] && !m_need_ds[1]));
        chk("u1.redirect_pc", redirect_pc1, m_pc[1]);
        chk("u1.br_count", 32'(br_count1), m_bc[1]);
        chk("u1.taken_count", 32'(taken_count1), m_tc[1]);
    endtask

    task automatic model_update();
        logic signed [31:0] off;
        bit tk;
        off = 32'($signed(imm16));
        tk  = (cmp_s != 0) != br_invert;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_hold[i] = 0; m_need_ds[i] = 0; m_pc[i] = '0; m_bc[i] = 0; m_tc[i] = 0;
            end else if (flush) begin
                m_hold[i] = 0; m_need_ds[i] = 0;
            end else if (!m_hold[i]) begin
                if (br_valid) begin
                    m_pc[i] = pc_plus4 + off * 4;
                    if (m_bc[i] < m_max[i]) m_bc[i]++;
                    if (tk) begin
                        if (m_tc[i] < m_max[i]) m_tc[i]++;
                        m_hold[i] = 1;
                        m_need_ds[i] = m_ds_en[i];
                    end
                end
            end else if (m_need_ds[i]) begin
                if (ds_issue) m_need_ds[i] = 0;
            end else if (redirect_ready) begin
                m_hold[i] = 0;
            end
        end
    endtask

    // Inputs are changed only at the negative edge; outputs are checked there.
    task automatic tick();
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 0; br_valid = 0; br_invert = 0; ds_issue = 0; flush = 0;
        redirect_ready = 0; cmp_s = '0; pc_plus4 = '0; imm16 = '0;
    endtask

    task automatic branch(input logic [31:0] c, input logic inv,
                          input logic [31:0] pc, input logic [15:0] im);
        br_valid = 1; cmp_s = c; br_invert = inv; pc_plus4 = pc; imm16 = im;
        tick();
        br_valid = 0;
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        reset = 1;
        tick(); tick();
        reset = 0;
        chk("reset.br_ready", 32'(br_ready0), 32'd1);
        chk("reset.redirect_valid", 32'(redirect_valid0), 32'd0);
        chk("reset.redirect_pc", redirect_pc0, 32'd0);
        chk("reset.br_count", 32'(br_count0), 32'd0);

        // 1: taken branch waits for delay slot
        branch(32'd1, 1'b0, 32'h0040_0004, 16'h0003);
        chk("t1.wait_ds_valid", 32'(redirect_valid0), 32'd0);
        tick();
        ds_issue = 1; tick(); ds_issue = 0;
        chk("t1.redirect_valid", 32'(redirect_valid0), 32'd1);
        chk("t1.redirect_pc", redirect_pc0, 32'h0040_0010);
        redirect_ready = 1; tick(); redirect_ready = 0;
        chk("t1.back_idle", 32'(br_ready0), 32'd1);
        chk("t1.taken_count", 32'(taken_count0), 32'd1);

        // 2: not-taken branch
        branch(32'd0, 1'b0, 32'h0000_1000, 16'h0010);
        tick(); tick();
        chk("t2.br_ready", 32'(br_ready0), 32'd1);
        chk("t2.br_count", 32'(br_count0), 32'd2);
        chk("t2.taken_count", 32'(taken_count0), 32'd1);

        // 3: wraparound target and a stalled redirect
        branch(32'hDEAD_0000, 1'b0, 32'h0000_0004, 16'hFFFE);
        ds_issue = 1; tick(); ds_issue = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t3.hold_valid", 32'(redirect_valid0), 32'd1);
            chk("t3.hold_pc", redirect_pc0, 32'hFFFF_FFFC);
            tick();
        end
        redirect_ready = 1; tick(); redirect_ready = 0;

        // 4a: flush with ds_issue in WAIT_DS, branch during flush not counted
        branch(32'd0, 1'b1, 32'h0000_2000, 16'h0004);
        flush = 1; ds_issue = 1; br_valid = 1; tick();
        flush = 0; ds_issue = 0; br_valid = 0;
        chk("t4.flush_idle", 32'(br_ready0), 32'd1);
        chk("t4.flush_br_count", 32'(br_count0), 32'd4);
        tick(); tick();
        // 4b: flush in REDIRECT with ready in the same cycle
        branch(32'd5, 1'b0, 32'h0000_3000, 16'h0001);
        ds_issue = 1; tick(); ds_issue = 0;
        flush = 1; redirect_ready = 1; tick(); flush = 0; redirect_ready = 0;
        chk("t4.flush_redirect", 32'(redirect_valid0), 32'd0);
        // 4c: reset mid-REDIRECT
        branch(32'd7, 1'b0, 32'h0000_4000, 16'h0002);
        ds_issue = 1; tick(); ds_issue = 0;
        reset = 1; flush = 1; tick(); reset = 0; flush = 0;
        chk("t4.rst_valid", 32'(redirect_valid0), 32'd0);
        chk("t4.rst_pc", redirect_pc0, 32'd0);
        chk("t4.rst_busy", 32'(busy0), 32'd0);
        chk("t4.rst_count", 32'(br_count0), 32'd0);

        // 5: five taken branches, ready tied high; u1 counters saturate at 3
        redirect_ready = 1; ds_issue = 1;
        for (int i = 0; i < 5; i++) begin
            branch(32'd1, 1'b0, 32'h0000_8000 + 32'(i) * 16, 16'h0008);
            chk("t5.latency", 32'(redirect_valid1), 32'd1);
            chk("t5.busy", 32'(br_ready1), 32'd0);
            tick(); tick();
        end
        chk("t5.br_sat", 32'(br_count1), 32'd3);
        chk("t5.taken_sat", 32'(taken_count1), 32'd3);
        redirect_ready = 0; ds_issue = 0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            br_valid       = ($urandom_range(0, 1) == 1);
            cmp_s          = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            br_invert      = ($urandom_range(0, 3) == 0);
            pc_plus4       = $urandom;
            imm16          = 16'($urandom);
            ds_issue       = ($urandom_range(0, 2) == 0);
            redirect_ready = ($urandom_range(0, 1) == 1);
            flush          = ($urandom_range(0, 19) == 0);
            reset          = ($urandom_range(0, 79) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
